// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a big-endian byte stream into SIZE-bit words
// and writes them one per cycle into the fetch stage's instruction memory.
// Optional inter-byte timeout abort is enabled with `define LOADER_TIMEOUT_EN.
module instr_mem_loader #(
  parameter int unsigned      SIZE            = 32,
  parameter int unsigned      MAX_INSTRUCTION = 64,
  parameter logic [SIZE-1:0]  HALT_WORD       = SIZE'(32'hFFFFFFFF),
  parameter int unsigned      TIMEOUT_CYCLES  = 1000,
  localparam int unsigned     ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_error
);

  localparam int unsigned NBYTES = SIZE / 8;
  localparam int unsigned BCNT_W = $clog2(NBYTES + 1);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [SIZE-1:0]       shift_q, shift_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [SIZE-1:0]       wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic                  accept_c;
  logic [SIZE-1:0]       word_c;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  error_q, error_d;
`else
  logic                  unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcnt_d   = bcnt_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    wcnt_d   = wcnt_q;
`ifdef LOADER_TIMEOUT_EN
    idle_d   = idle_q;
    error_d  = error_q;
`endif
    accept_c = i_byte_valid && ready_q;
    word_c   = SIZE'({shift_q, i_byte});

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_RECV;
          shift_d = '0;
          bcnt_d  = '0;
          addr_d  = '0;
          wcnt_d  = '0;
`ifdef LOADER_TIMEOUT_EN
          idle_d  = '0;
          error_d = 1'b0;
`endif
        end
      end
      S_RECV: begin
        if (accept_c) begin
          shift_d = word_c;
          bcnt_d  = bcnt_q + BCNT_W'(1);
`ifdef LOADER_TIMEOUT_EN
          idle_d  = '0;
`endif
          if (bcnt_q == BCNT_W'(NBYTES - 1)) begin
            bcnt_d = '0;
            if (word_c == HALT_WORD) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WRITE;
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = word_c;
            end
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          bcnt_d  = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        wcnt_d = wcnt_q + CNT_W'(1);
        bcnt_d = '0;
`ifdef LOADER_TIMEOUT_EN
        idle_d = '0;
`endif
        state_d = (addr_q == ADDR_WIDTH'(MAX_INSTRUCTION - 1)) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_RECV);
    busy_d  = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs; async active-low reset clears everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
`ifdef LOADER_TIMEOUT_EN
      idle_q  <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
`ifdef LOADER_TIMEOUT_EN
      idle_q  <= idle_d;
      error_q <= error_d;
`endif
    end
  end

  assign o_byte_ready        = ready_q;
  assign o_inst_write_enable = we_q;
  assign o_write_addr        = waddr_q;
  assign o_write_data        = wdata_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_word_count        = wcnt_q;
`ifdef LOADER_TIMEOUT_EN
  assign o_error             = error_q;
`else
  assign o_error             = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: random word streams checked against a
// queue-based model of the expected memory writes.
module tb_instr_mem_loader;
  localparam int unsigned AW   = 6;
  localparam int unsigned MAXI = 64;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TB_TO = 10;
`else
  localparam int unsigned TB_TO = 1000;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic          o_inst_write_enable;
  logic [AW-1:0] o_write_addr;
  logic [31:0]   o_write_data;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_word_count;
  logic          o_error;

  instr_mem_loader #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_inst_write_enable(o_inst_write_enable), .o_write_addr(o_write_addr),
    .o_write_data(o_write_data), .o_busy(o_busy), .o_done(o_done),
    .o_word_count(o_word_count), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   we_double = 0;
  logic prev_we = 1'b0;
  wr_t  got[$];
  wr_t  exp_q[$];

  always @(posedge i_clk) cyc++;

  // Memory-side observer: record writes the way the negedge memory captures them.
  always @(negedge i_clk) begin
    if (o_inst_write_enable) got.push_back('{o_write_addr, o_write_data});
    if (o_inst_write_enable && prev_we) we_double++;
    prev_we = o_inst_write_enable;
  end

  // Reference: words written in order from addr 0 until halt or memory full.
  function automatic void model(input logic [31:0] words[$]);
    bit stop = 1'b0;
    exp_q.delete();
    for (int i = 0; i < words.size() && !stop; i++) begin
      if (words[i] == HALT || exp_q.size() == MAXI) stop = 1'b1;
      else exp_q.push_back('{AW'(exp_q.size()), words[i]});
    end
  endfunction

  function automatic bit writes_match();
    if (got.size() != exp_q.size()) return 1'b0;
    foreach (got[i]) if (got[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_start();
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
  endtask

  // Offer bytes with optional random gaps; a byte moves on only when ready was high.
  task automatic send_bytes(input logic [7:0] b[$], input int max_gap);
    int i = 0;
    int guard = 0;
    int gap_left = 0;
    while (i < b.size() && guard < 5000) begin
      @(negedge i_clk);
      if (gap_left > 0) begin
        i_byte_valid = 1'b0;
        gap_left--;
      end else begin
        i_byte_valid = 1'b1;
        i_byte = b[i];
        if (o_byte_ready) begin
          i++;
          gap_left = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        end
      end
      guard++;
    end
    @(negedge i_clk) i_byte_valid = 1'b0;
    tests++;
    if (i != b.size()) begin
      fails++;
      $display("FAIL send_bytes: accepted %0d bytes, required %0d", i, b.size());
    end
  endtask

  task automatic send_words(input logic [31:0] w[$], input int max_gap);
    logic [7:0] bq[$];
    foreach (w[k]) begin
      bq.push_back(w[k][31:24]); bq.push_back(w[k][23:16]);
      bq.push_back(w[k][15:8]);  bq.push_back(w[k][7:0]);
    end
    send_bytes(bq, max_gap);
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!o_done && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    ok = o_done;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    tests++;
    if ({o_byte_ready, o_inst_write_enable, o_busy, o_done, o_error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000",
               {o_byte_ready, o_inst_write_enable, o_busy, o_done, o_error});
    end
    tests++;
    if ({o_write_addr, o_write_data, o_word_count} !== '0) begin
      fails++;
      $display("FAIL reset_values: addr %0h data %0h count %0d required all 0",
               o_write_addr, o_write_data, o_word_count);
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    tests++;
    if ({o_busy, o_byte_ready} !== 2'b00) begin
      fails++;
      $display("FAIL idle_flags: busy/ready %b required 00", {o_busy, o_byte_ready});
    end
  endtask

  task automatic test_single();
    logic [31:0] ws[$];
    bit ok;
    ws = '{32'h3C010003, HALT};
    got.delete();
    pulse_start();
    send_words(ws, 0);
    wait_done(ok);
    model(ws);
    tests++;
    if (!writes_match()) begin
      fails++;
      $display("FAIL single_writes: got %0d writes (first %h) required addr 0 data 3c010003",
               got.size(), (got.size() > 0) ? got[0] : wr_t'(0));
    end
    tests++;
    if ({ok, o_busy, o_word_count} !== {1'b1, 1'b0, 7'd1}) begin
      fails++;
      $display("FAIL single_status: done %b busy %b count %0d required 1 0 1", ok, o_busy, o_word_count);
    end
    tests++;
    if ({o_write_addr, o_write_data} !== {6'd0, 32'h3C010003}) begin
      fails++;
      $display("FAIL single_hold: addr %0d data %h required 0 3c010003", o_write_addr, o_write_data);
    end
  endtask

  task automatic test_multi();
    logic [31:0] ws[$];
    bit ok;
    for (int k = 0; k < 3; k++) ws.push_back(rand_word());
    ws.push_back(HALT);
    got.delete();
    we_double = 0;
    pulse_start();
    send_words(ws, 2);
    wait_done(ok);
    model(ws);
    tests++;
    if (!writes_match()) begin
      fails++;
      $display("FAIL multi_writes: got %0d writes required %0d", got.size(), exp_q.size());
    end
    tests++;
    if ({ok, o_word_count, we_double} !== {1'b1, 7'd3, 32'd0}) begin
      fails++;
      $display("FAIL multi_status: done %b count %0d long_strobes %0d required 1 3 0",
               ok, o_word_count, we_double);
    end
  endtask

  task automatic test_full();
    logic [31:0] ws[$];
    bit ok;
    int rdy_seen = 0;
    for (int k = 0; k < MAXI; k++) ws.push_back(rand_word());
    got.delete();
    pulse_start();
    send_words(ws, 1);
    wait_done(ok);
    model(ws);
    tests++;
    if (!writes_match() || got[$].addr !== 6'd63) begin
      fails++;
      $display("FAIL full_writes: got %0d writes required 64 ending at addr 63", got.size());
    end
    tests++;
    if ({ok, o_word_count} !== {1'b1, 7'd64}) begin
      fails++;
      $display("FAIL full_status: done %b count %0d required 1 64", ok, o_word_count);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte = 8'hA5;
      if (o_byte_ready) rdy_seen++;
    end
    @(negedge i_clk) i_byte_valid = 1'b0;
    tests++;
    if (rdy_seen != 0 || got.size() != MAXI) begin
      fails++;
      $display("FAIL full_extra: ready seen %0d writes %0d required 0 and 64", rdy_seen, got.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws[$];
    bit ok;
    int c0;
    for (int k = 0; k < 5; k++) ws.push_back(rand_word());
    ws.push_back(HALT);
    got.delete();
    we_double = 0;
    pulse_start();
    c0 = cyc;
    fork
      send_words(ws, 0);
      begin
        for (int k = 0; k < 6; k++) begin
          repeat (2) @(negedge i_clk);
          i_start = 1'b1;
          @(negedge i_clk) i_start = 1'b0;
        end
      end
    join
    wait_done(ok);
    model(ws);
    tests++;
    if (!writes_match()) begin
      fails++;
      $display("FAIL b2b_writes: got %0d writes required %0d", got.size(), exp_q.size());
    end
    tests++;
    if ({ok, o_word_count, we_double} !== {1'b1, 7'd5, 32'd0}) begin
      fails++;
      $display("FAIL b2b_status: done %b count %0d long_strobes %0d required 1 5 0",
               ok, o_word_count, we_double);
    end
    tests++;
    if (cyc - c0 != 30) begin
      fails++;
      $display("FAIL b2b_cycles: load took %0d cycles required 30", cyc - c0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  bq[$];
    logic [31:0] ws[$];
    bit ok;
    bq = '{8'hAB, 8'hCD};
    pulse_start();
    send_bytes(bq, 0);
    #2 i_rst_n = 1'b0;
    #1;
    tests++;
    if ({o_busy, o_byte_ready, o_word_count} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: busy %b ready %b count %0d required 0 0 0",
               o_busy, o_byte_ready, o_word_count);
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    ws = '{32'h00000000, HALT};
    got.delete();
    pulse_start();
    send_words(ws, 0);
    wait_done(ok);
    model(ws);
    tests++;
    if (!writes_match() || o_word_count !== 7'd1) begin
      fails++;
      $display("FAIL midreset_restart: got %0d writes (first %h) count %0d required addr 0 data 0 count 1",
               got.size(), (got.size() > 0) ? got[0] : wr_t'(0), o_word_count);
    end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] bq[$];
    bq = '{8'h12, 8'h34};
    got.delete();
    pulse_start();
    send_bytes(bq, 0);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if ({o_error, o_busy} !== 2'b01) begin
      fails++;
      $display("FAIL timeout_early: error/busy %b required 01 after 9 idle cycles", {o_error, o_busy});
    end
    @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if ({o_error, o_busy, o_byte_ready, o_done} !== 4'b1000 || got.size() != 0 || o_word_count !== 7'd0) begin
      fails++;
      $display("FAIL timeout_abort: err/busy/ready/done %b writes %0d count %0d required 1000 0 0",
               {o_error, o_busy, o_byte_ready, o_done}, got.size(), o_word_count);
    end
    pulse_start();
    tests++;
    if ({o_error, o_busy} !== 2'b01) begin
      fails++;
      $display("FAIL timeout_clear: error/busy %b required 01", {o_error, o_busy});
    end
    i_rst_n = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
